uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 7 +
 rtl/uart_tx_arbiter_rr_picker.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM state type and arbiter limits
package uart_tx_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
  localparam int N_REQ_MAX = 8;
  localparam int LOCK_BURST_MAX = 16;
  localparam int IW = $clog2(N_REQ_MAX);
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: round-robin search over a request vector starting at a pointer
module rr_picker import uart_tx_arbiter_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          valid_o,
  output logic [IW-1:0] idx_o
);
  always_comb begin
    int j;
    logic [N-1:0] req_sh;
    j = 0;
    req_sh = '0;
    idx_o = '0;
    // Walk from the farthest offset back so the nearest requester wins last
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start_i) + k;
      j = (j >= N) ? j - N : j;
      req_sh = req_i >> j;
      if (req_sh[0]) idx_o = IW'(j);
    end
    valid_o = |req_i;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding bytes from N_REQ requesters into one UART transmitter.
// Optional burst lock enabled with UART_TX_ARB_LOCK_EN.
module uart_tx_arbiter import uart_tx_arbiter_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*8-1:0] req_data,
  input  logic [N_REQ-1:0]   req_lock,
  output logic [N_REQ-1:0]   req_ack,
  output logic               tx_send_req,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic [2:0]         grant_id,
  output logic               arb_active
);
  state_e state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [IW-1:0] grant_q, grant_d, rr_q, rr_d, nxt, pick_idx;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic send_q, send_d, pick_v;
  logic [N_REQ*8-1:0] data_sh;

  rr_picker #(.N(N_REQ)) u_pick (
    .req_i  (req_valid),
    .start_i(rr_q),
    .valid_o(pick_v),
    .idx_o  (pick_idx)
  );

  assign data_sh = req_data >> (8 * pick_idx);
  assign nxt = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
  logic [3:0] cnt_q, cnt_d;
  logic lock_hold;
  // Hold the pointer on a locked requester until it has sent LOCK_BURST_MAX bytes in a row
  assign lock_hold = |(req_lock & (N_REQ'(1) << grant_q)) && cnt_q != 4'(LOCK_BURST_MAX - 1);
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    state_d = state_q;
    data_d = data_q;
    grant_d = grant_q;
    rr_d = rr_q;
    ack_d = '0;
    send_d = send_q;
`ifdef UART_TX_ARB_LOCK_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (!tx_busy && pick_v) begin
        data_d = data_sh[7:0];
        grant_d = pick_idx;
        ack_d = N_REQ'(1) << pick_idx;
        send_d = 1'b1;
        state_d = ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
        cnt_d = (pick_idx != grant_q) ? '0 : cnt_q;
`endif
      end
      ISSUE: if (tx_busy) begin
        send_d = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: if (!tx_busy) begin
        state_d = IDLE;
`ifdef UART_TX_ARB_LOCK_EN
        rr_d = lock_hold ? grant_q : nxt;
        cnt_d = lock_hold ? cnt_q + 4'd1 : '0;
`else
        rr_d = nxt;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q <= '0;
      grant_q <= '0;
      rr_q <= '0;
      ack_q <= '0;
      send_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      ack_q <= ack_d;
      send_q <= send_d;
`ifdef UART_TX_ARB_LOCK_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign req_ack = ack_q;
  assign tx_send_req = send_q;
  assign tx_data = data_q;
  assign grant_id = 3'(grant_q);
  assign arb_active = state_q != IDLE;
endmodule
